// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: sequencer state encoding, boot/exception
// vectors and an address alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its neighbours: PC block, instruction
// memory port, decode stage and the redirect/exception sources.
interface fetch_sequencer_if;

  logic [31:0] pc_address;
  logic        pc_count;
  logic        pc_use_new;
  logic [31:0] pc_new;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exception;
  logic        fetch_fault;

  // Sequencer side: drives PC controls, fetch requests and decode handoff.
  modport master (
    input  pc_address,
    input  imem_ready,
    input  imem_rdata,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  exception,
    output pc_count,
    output pc_use_new,
    output pc_new,
    output imem_req,
    output imem_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    output fetch_fault
  );

  // Environment side: PC block, memory, decode and control sources.
  modport slave (
    output pc_address,
    output imem_ready,
    output imem_rdata,
    output stall,
    output redirect_valid,
    output redirect_target,
    output exception,
    input  pc_count,
    input  pc_use_new,
    input  pc_new,
    input  imem_req,
    input  imem_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  fetch_fault
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Saturating wait counter for outstanding fetches; flags when the wait has
// reached TIMEOUT-1 cycles.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LIMIT   = W'(TIMEOUT - 1);
  localparam logic [W-1:0] SAT_MAX = {W{1'b1}};

  logic [W-1:0] count_r;

  // Count waiting cycles; clear wins, and the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != SAT_MAX)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r >= LIMIT);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the PC block through sequential fetch, redirects and
// exception vectoring, and hands fetched words to decode under backpressure.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          TIMEOUT      = 16
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  // RESET_VECTOR is only a reference: the PC block resets itself to it.
  if ((TIMEOUT < 2) || !is_word_aligned(RESET_VECTOR) || !is_word_aligned(EXC_VECTOR)) begin : g_param_check
    $error("fetch_sequencer: TIMEOUT must be >= 2 and vectors word aligned");
  end

  fetch_state_e state_r;
  logic [31:0]  instr_r;
  logic [31:0]  instr_pc_r;
  logic         instr_valid_r;
  logic         fault_r;

  logic in_fetch_s;
  logic live_s;
  logic exc_s;
  logic redir_live_s;
  logic redir_ok_s;
  logic redir_bad_s;
  logic accept_s;
  logic timeout_s;
  logic cnt_clear_s;
  logic cnt_enable_s;
  logic expired_s;

  // Event decode in priority order: exception, bad redirect, redirect, fetch data.
  always_comb begin
    in_fetch_s   = (state_r == FETCH);
    live_s       = (state_r != BOOT);
    exc_s        = live_s && bus.exception;
    redir_live_s = live_s && (state_r != FAULT) && bus.redirect_valid && !exc_s;
    redir_ok_s   = redir_live_s && is_word_aligned(bus.redirect_target);
    redir_bad_s  = redir_live_s && !is_word_aligned(bus.redirect_target);
    accept_s     = in_fetch_s && bus.imem_ready && !exc_s && !redir_live_s;
    timeout_s    = in_fetch_s && !bus.imem_ready && expired_s;
    cnt_clear_s  = exc_s || redir_ok_s || accept_s;
    cnt_enable_s = in_fetch_s && !bus.imem_ready;
  end

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear_s),
    .enable  (cnt_enable_s),
    .expired (expired_s)
  );

  // PC block controls and memory request; a load always overrides counting.
  always_comb begin
    bus.pc_count   = accept_s;
    bus.pc_use_new = exc_s || redir_ok_s;
    if (exc_s) begin
      bus.pc_new = EXC_VECTOR;
    end else if (redir_ok_s) begin
      bus.pc_new = bus.redirect_target;
    end else begin
      bus.pc_new = 32'h0000_0000;
    end
    bus.imem_req = in_fetch_s;
    if (in_fetch_s) begin
      bus.imem_addr = bus.pc_address;
    end else begin
      bus.imem_addr = 32'h0000_0000;
    end
  end

  // Sequencer state and registered decode-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= BOOT;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
    end else if (state_r == BOOT) begin
      state_r <= FETCH;
    end else if (exc_s) begin
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
      state_r       <= FETCH;
    end else if (redir_bad_s) begin
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b1;
      state_r       <= FAULT;
    end else if (redir_ok_s) begin
      instr_valid_r <= 1'b0;
      state_r       <= FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          if (bus.imem_ready) begin
            instr_r       <= bus.imem_rdata;
            instr_pc_r    <= bus.pc_address;
            instr_valid_r <= 1'b1;
            state_r       <= HOLD;
          end else if (timeout_s) begin
            fault_r <= 1'b1;
            state_r <= FAULT;
          end else begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          // The handoff cycle doubles as the re-request bubble.
          if (instr_valid_r && !bus.stall) begin
            instr_valid_r <= 1'b0;
            state_r       <= FETCH;
          end else begin
            state_r <= HOLD;
          end
        end
        FAULT: begin
          instr_valid_r <= 1'b0;
          state_r       <= FAULT;
        end
        default: begin
          instr_valid_r <= 1'b0;
          state_r       <= BOOT;
        end
      endcase
    end
  end

  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level model predicts PC
// control events and delivered instructions; a monitor compares them.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_VEC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  localparam int          TMO     = 16;

  typedef struct packed {
    logic        cnt;
    logic        use_new;
    logic [31:0] target;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_VECTOR (RST_VEC),
    .EXC_VECTOR   (EXC_VEC),
    .TIMEOUT      (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  ctrl_t       ctrl_q[$];
  xfer_t       xfer_q[$];
  logic [31:0] mdl_pc;
  logic        mdl_fault;
  logic        done;
  int          wait_cnt;

  always #5 clk = ~clk;

  // PC block stand-in
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.pc_address <= RST_VEC;
    else if (bus.pc_use_new) bus.pc_address <= bus.pc_new;
    else if (bus.pc_count) bus.pc_address <= bus.pc_address + 32'd4;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_VEC) return 32'h2008_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and predict what the sequencer must do with them.
  task automatic drive(input logic rdy, input logic stl, input logic rv,
                       input logic [31:0] tgt, input logic ex);
    ctrl_t c;
    xfer_t x;
    bus.imem_ready      = rdy;
    bus.stall           = stl;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.exception       = ex;
    bus.imem_rdata      = bus.imem_req ? mem_word(bus.imem_addr) : 32'($urandom());
    if (ex) begin
      c.cnt = 1'b0; c.use_new = 1'b1; c.target = EXC_VEC;
      ctrl_q.push_back(c);
      mdl_pc    = EXC_VEC;
      mdl_fault = 1'b0;
    end else if (rv && !mdl_fault) begin
      if (tgt[1:0] == 2'b00) begin
        c.cnt = 1'b0; c.use_new = 1'b1; c.target = tgt;
        ctrl_q.push_back(c);
        mdl_pc = tgt;
      end else begin
        mdl_fault = 1'b1;
      end
    end else if (bus.imem_req && rdy) begin
      c.cnt = 1'b1; c.use_new = 1'b0; c.target = 32'h0;
      ctrl_q.push_back(c);
      x.pc = mdl_pc; x.word = mem_word(mdl_pc);
      xfer_q.push_back(x);
      mdl_pc = mdl_pc + 32'd4;
    end
  endtask

  task automatic step(input logic rdy, input logic stl, input logic rv,
                      input logic [31:0] tgt, input logic ex);
    @(posedge clk);
    #1;
    drive(rdy, stl, rv, tgt, ex);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0; bus.stall = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0; bus.exception = 1'b0;
    mdl_pc = RST_VEC; mdl_fault = 1'b0; done = 1'b0; wait_cnt = 0;
    #2 rst = 1'b0;

    fork
      begin : monitor
        ctrl_t c;
        xfer_t x;
        while (!done) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            if (bus.pc_count || bus.pc_use_new || ctrl_q.size() != 0) begin
              if (ctrl_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pc_ctrl actual count=%b use_new=%b new=%h required no PC control",
                         bus.pc_count, bus.pc_use_new, bus.pc_new);
              end else begin
                c = ctrl_q.pop_front();
                chk("pc_count", 32'(bus.pc_count), 32'(c.cnt));
                chk("pc_use_new", 32'(bus.pc_use_new), 32'(c.use_new));
                chk("pc_new", bus.pc_new, c.target);
              end
            end
            if (bus.instr_valid && !bus.stall) begin
              if (xfer_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL xfer actual pc=%h instr=%h required no transfer", bus.instr_pc, bus.instr);
              end else begin
                x = xfer_q.pop_front();
                chk("xfer_pc", bus.instr_pc, x.pc);
                chk("xfer_instr", bus.instr, x.word);
              end
            end
          end
        end
      end

      begin : stimulus
        int n;
        logic drained;
        repeat (2) @(negedge clk);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc_ctrl", {30'd0, bus.pc_count, bus.pc_use_new}, 32'd0);

        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("boot_req", 32'(bus.imem_req), 32'd0);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RST_VEC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 3; i++) begin
          step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
          chk("hold_valid", 32'(bus.instr_valid), 32'd1);
          chk("hold_instr", bus.instr, 32'h2008_0005);
          chk("hold_pc", bus.instr_pc, RST_VEC);
          chk("hold_req", 32'(bus.imem_req), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq_addr", bus.imem_addr, 32'h0040_0004);

        step(1'b1, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
        chk("redir_drop_valid", 32'(bus.instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_addr", bus.imem_addr, 32'h0040_0100);
        chk("redir_valid", 32'(bus.instr_valid), 32'd0);

        step(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b1);

        n = 0;
        for (int i = 0; i < 40; i++) begin
          step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
          if (i == 0) chk("exc_addr", bus.imem_addr, EXC_VEC);
          if (bus.fetch_fault) break;
          n++;
        end
        chk("timeout_cycles", n, TMO);
        mdl_fault = 1'b1;

        for (int i = 0; i < 3; i++) begin
          step(1'b1, 1'b0, 1'b1, 32'h0040_0300, 1'b0);
          chk("fault_sticky", 32'(bus.fetch_fault), 32'd1);
          chk("fault_req", 32'(bus.imem_req), 32'd0);
          chk("fault_valid", 32'(bus.instr_valid), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("recover_fault", 32'(bus.fetch_fault), 32'd0);
        chk("recover_addr", bus.imem_addr, EXC_VEC);

        wait_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
          logic r, s, v, e;
          logic [31:0] t;
          @(posedge clk);
          #1;
          if (bus.imem_req) begin
            r = (wait_cnt >= 6) || ($urandom_range(2, 0) == 32'd0);
            v = ($urandom_range(9, 0) == 32'd0);
            e = ($urandom_range(39, 0) == 32'd0);
          end else begin
            r = ($urandom_range(1, 0) == 32'd1);
            v = 1'b0;
            e = 1'b0;
          end
          s = ($urandom_range(2, 0) == 32'd0);
          t = 32'h0040_0000 | ($urandom() & 32'h0000_0ffc);
          wait_cnt = (bus.imem_req && !r && !v && !e) ? wait_cnt + 1 : 0;
          drive(r, s, v, t, e);
          @(negedge clk);
        end

        drained = 1'b0;
        for (int i = 0; i < 80; i++) begin
          step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
          if (bus.imem_req && xfer_q.size() == 0) begin
            drained = 1'b1;
            break;
          end
        end
        chk("drain", 32'(drained), 32'd1);

        step(1'b1, 1'b0, 1'b1, 32'h0040_0102, 1'b0);
        chk("misalign_use_new", 32'(bus.pc_use_new), 32'd0);
        chk("misalign_count", 32'(bus.pc_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("misalign_fault", 32'(bus.fetch_fault), 32'd1);
        chk("misalign_req", 32'(bus.imem_req), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", bus.imem_addr, EXC_VEC);
        chk("ctrl_q_empty", ctrl_q.size(), 32'd0);
        chk("xfer_q_empty", xfer_q.size(), 32'd0);

        #2 rst = 1'b0;
        #1;
        chk("async_req", 32'(bus.imem_req), 32'd0);
        chk("async_addr", bus.imem_addr, 32'h0);
        chk("async_pc_ctrl", {30'd0, bus.pc_count, bus.pc_use_new}, 32'd0);
        chk("async_pc_new", bus.pc_new, 32'h0);
        chk("async_valid", 32'(bus.instr_valid), 32'd0);
        chk("async_instr", bus.instr, 32'h0);
        chk("async_instr_pc", bus.instr_pc, 32'h0);
        chk("async_fault", 32'(bus.fetch_fault), 32'd0);
        repeat (2) @(posedge clk);
        done = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the program counter block and the instruction-memory fetch port of the MIPS core.
- Issues fetch requests at the current PC and presents fetched instructions to decode with backpressure.
- Drives the PC block's count/load controls for sequential advance, branch/jump redirects and exception vectoring.
- Detects fetch timeouts and misaligned redirect targets.

Parameters:
- RESET_VECTOR, 32'h00400000, PC value after reset; reporting only, since the PC block self-resets to it.
- EXC_VECTOR, 32'h80000180, target loaded on exception.
- TIMEOUT, 16, cycles in FETCH without imem_ready before a fault is raised. Must be ≥2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- pc_address  in  32  current PC from the PC block
- pc_count  out  1  PC block count enable (PC <= PC+4)
- pc_use_new  out  1  PC block load select
- pc_new  out  32  PC block load value
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ready  in  1  fetch data valid; meaningful only while imem_req=1
- imem_rdata  in  32  fetched word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  instruction word
- instr_pc  out  32  address of instr
- stall  in  1  decode backpressure; transfer occurs when instr_valid & !stall
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_target  in  32  branch/jump target
- exception  in  1  exception request, one-cycle pulse
- fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT; instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, timeout counter=0.
  - Combinational outputs evaluate to 0 in BOOT.
- State machine: BOOT, FETCH, HOLD, FAULT.
- BOOT: go to FETCH unconditionally after one cycle.
- FETCH:
  - imem_req=1, imem_addr=pc_address (combinational).
  - Timeout counter increments each cycle without imem_ready.
  - On imem_ready:
    - register instr<=imem_rdata, instr_pc<=pc_address, instr_valid<=1;
    - pc_count=1 and pc_use_new=0 in that same cycle;
    - clear counter; go to HOLD.
  - Fetch latency is ≥1 cycle from request to instr_valid.
- HOLD:
  - imem_req=0; instr, instr_pc and instr_valid are stable.
  - When instr_valid & !stall: instr_valid<=0 and go to FETCH. Transfer and re-request cost one cycle.
  - While stall=1: no pc_count, no request.
- Redirect/exception priority: exception > misaligned redirect > redirect > normal count. Evaluated in every state except BOOT.
  - Exception: pc_use_new=1, pc_count=0, pc_new=EXC_VECTOR; instr_valid<=0; clear fault and counter; go to FETCH.
  - Redirect with target[1:0]==0 (not in FAULT): pc_use_new=1, pc_count=0, pc_new=redirect_target; instr_valid<=0; clear counter; go to FETCH.
  - Redirect with target[1:0]!=0: no PC load (pc_use_new=0); fetch_fault<=1; instr_valid<=0; go to FAULT.
  - A redirect or exception coincident with imem_ready in FETCH discards imem_rdata and suppresses the normal pc_count.
  - The new address appears on imem_addr the following cycle.
- Timeout: when the counter reaches TIMEOUT-1 without imem_ready, fetch_fault<=1 and go to FAULT at the next edge.
- FAULT:
  - imem_req=0, pc_count=0, instr_valid=0.
  - redirect_valid is ignored.
  - Exit only via exception (to FETCH, fault cleared) or reset.
- pc_new defaults to 0 whenever pc_use_new=0.
- Counter width is $clog2(TIMEOUT)+1. It saturates and never wraps.
- Reset asserted mid-FETCH drops imem_req immediately and clears all state; no PC control is issued.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_e enum (BOOT, FETCH, HOLD, FAULT);
  - localparams RESET_VECTOR_DEF and EXC_VECTOR_DEF;
  - function is_word_aligned(addr).
- One natural sub-module: fetch_timeout_counter (clear, enable, expired output, parameterised by TIMEOUT).
- FSM and PC-control muxing stay in fetch_sequencer.

Test Plan:
- Release rst with pc_address=0x00400000; assert imem_ready 2 cycles later with rdata 0x20080005 -> instr_valid=1, instr=0x20080005, instr_pc=0x00400000; single-cycle pc_count pulse; next imem_addr=0x00400004.
- Hold stall=1 for 3 cycles while in HOLD -> instr stable, imem_req=0, pc_count=0. Release stall -> one transfer cycle, then FETCH at 0x00400004.
- In FETCH, pulse redirect_valid with target 0x00400100 in the same cycle as imem_ready -> data dropped, instr_valid stays 0, pc_use_new=1, pc_count=0, pc_new=0x00400100; next imem_addr=0x00400100.
- Pulse exception and redirect_valid (0x00400200) together -> pc_new=0x80000180, pc_use_new=1.
- Hold imem_ready=0 in FETCH -> fetch_fault=1 after 16 cycles and stays sticky; a later redirect is ignored. Exception pulse -> fault cleared, FETCH at 0x80000180.
- Redirect to 0x00400102 -> fetch_fault=1, pc_use_new=0. Then assert rst mid-FETCH -> imem_req=0 and all outputs 0 asynchronously.
